// File: rtl/fp_operand_loader.sv
// Operand-entry front end for the FP adder: builds two IEEE-754 singles from
// debounced byte entries and presents them with a valid/ack handshake.

module fp_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   deb_q;
    logic                   deb_d;
    logic                   deb_dly_q;
    logic                   sync_s;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign pulse_o = deb_q & ~deb_dly_q;

    // Debounced level follows the synchronized input only after a full run of disagreement
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync_s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Synchronizer, debounce counter and edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end
endmodule

module fp_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sw,
    input  logic        btn_load,
    input  logic        btn_clear,
    input  logic        op_ack,
    output logic [31:0] n0,
    output logic [31:0] n1,
    output logic        op_valid,
    output logic        op_special,
    output logic [3:0]  leds
);
    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] stage_a_q, stage_a_d;
    logic [31:0] stage_b_q, stage_b_d;
    logic [31:0] n0_q, n0_d;
    logic [31:0] n1_q, n1_d;
    logic        op_valid_q, op_valid_d;
    logic        op_special_q, op_special_d;
    logic [3:0]  leds_q, leds_d;
    logic        load_pulse_s;
    logic        clear_pulse_s;

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Zero/denormal or Inf/NaN exponent
    function automatic logic is_special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
    endfunction

    fp_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_load_cond (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_load),
        .pulse_o (load_pulse_s)
    );

    fp_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clear_cond (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_clear),
        .pulse_o (clear_pulse_s)
    );

    // State register plus staged operands and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD_A;
            idx_q        <= 2'd0;
            stage_a_q    <= 32'd0;
            stage_b_q    <= 32'd0;
            n0_q         <= 32'd0;
            n1_q         <= 32'd0;
            op_valid_q   <= 1'b0;
            op_special_q <= 1'b0;
            leds_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            stage_a_q    <= stage_a_d;
            stage_b_q    <= stage_b_d;
            n0_q         <= n0_d;
            n1_q         <= n1_d;
            op_valid_q   <= op_valid_d;
            op_special_q <= op_special_d;
            leds_q       <= leds_d;
        end
    end

    // Next-state: clear wins over everything; n0/n1/op_special only change on a completed entry
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        stage_a_d    = stage_a_q;
        stage_b_d    = stage_b_q;
        n0_d         = n0_q;
        n1_d         = n1_q;
        op_valid_d   = op_valid_q;
        op_special_d = op_special_q;
        if (clear_pulse_s) begin
            state_d    = ST_LOAD_A;
            idx_d      = 2'd0;
            stage_a_d  = 32'd0;
            stage_b_d  = 32'd0;
            op_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (load_pulse_s) begin
                        stage_a_d = put_byte(stage_a_q, idx_q, sw);
                        idx_d     = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = ST_LOAD_B;
                        end else begin
                            state_d = ST_LOAD_A;
                        end
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (load_pulse_s) begin
                        stage_b_d = put_byte(stage_b_q, idx_q, sw);
                        idx_d     = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            n0_d         = stage_a_q;
                            n1_d         = {stage_b_q[31:8], sw};
                            op_valid_d   = 1'b1;
                            op_special_d = is_special(stage_a_q) | is_special({stage_b_q[31:8], sw});
                            state_d      = ST_READY;
                        end else begin
                            state_d = ST_LOAD_B;
                        end
                    end else begin
                        state_d = ST_LOAD_B;
                    end
                end
                ST_READY: begin
                    if (op_ack) begin
                        op_valid_d = 1'b0;
                        state_d    = ST_LOAD_A;
                        idx_d      = 2'd0;
                        stage_a_d  = 32'd0;
                        stage_b_d  = 32'd0;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d    = ST_LOAD_A;
                    idx_d      = 2'd0;
                    stage_a_d  = 32'd0;
                    stage_b_d  = 32'd0;
                    op_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Progress LEDs are registered from the next-state values so they align with op_valid
    always_comb begin
        leds_d = {op_valid_d, (state_d == ST_LOAD_B), idx_d};
    end

    assign n0         = n0_q;
    assign n1         = n1_q;
    assign op_valid   = op_valid_q;
    assign op_special = op_special_q;
    assign leds       = leds_q;
endmodule

// File: tb/tb_fp_operand_loader.sv
// Self-checking bench for fp_operand_loader: directed scenarios followed by
// randomized presses, bounces, clears and acks against a byte-queue model.

module tb_fp_operand_loader;
    logic        clk;
    logic        reset;
    logic [7:0]  sw;
    logic        btn_load;
    logic        btn_clear;
    logic        op_ack;
    logic [31:0] n0;
    logic [31:0] n1;
    logic        op_valid;
    logic        op_special;
    logic [3:0]  leds;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: bytes entered so far, last published operands
    logic [7:0]  m_q[$];
    logic [31:0] m_n0;
    logic [31:0] m_n1;
    logic        m_valid;
    logic        m_special;

    fp_operand_loader #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_clear  (btn_clear),
        .op_ack     (op_ack),
        .n0         (n0),
        .n1         (n1),
        .op_valid   (op_valid),
        .op_special (op_special),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic m_is_special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_n0 = 32'd0; m_n1 = 32'd0; m_valid = 1'b0; m_special = 1'b0;
    endtask

    task automatic m_clear();
        m_q.delete();
        m_valid = 1'b0;
    endtask

    task automatic m_load(input logic [7:0] b);
        if (m_q.size() < 8) begin
            m_q.push_back(b);
            if (m_q.size() == 8) begin
                m_n0      = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_n1      = {m_q[4], m_q[5], m_q[6], m_q[7]};
                m_valid   = 1'b1;
                m_special = m_is_special(m_n0) | m_is_special(m_n1);
            end
        end
    endtask

    task automatic m_ack();
        if (m_q.size() == 8) begin
            m_q.delete();
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [3:0] m_leds();
        int sz;
        sz = m_q.size();
        if (sz == 8) return 4'b1000;
        return {1'b0, (sz >= 4), 2'(sz % 4)};
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".n0"}, n0, m_n0);
        check_val({tag, ".n1"}, n1, m_n1);
        check_val({tag, ".valid"}, {31'd0, op_valid}, {31'd0, m_valid});
        check_val({tag, ".special"}, {31'd0, op_special}, {31'd0, m_special});
        check_val({tag, ".leds"}, {28'd0, leds}, {28'd0, m_leds()});
    endtask

    // Clean press of load and/or clear, long enough to debounce both edges
    task automatic press(input logic [7:0] b, input logic ld, input logic cl);
        sw        = b;
        btn_load  = ld;
        btn_clear = cl;
        tick(8);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        tick(8);
        if (cl) m_clear();
        else if (ld) m_load(b);
    endtask

    task automatic ack_pulse();
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        m_ack();
    endtask

    task automatic enter8(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) press(bytes[63-8*i -: 8], 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] specials [4];
        specials[0] = 8'h00; specials[1] = 8'h7F; specials[2] = 8'hFF; specials[3] = 8'h80;
        sw = 8'd0; btn_load = 1'b0; btn_clear = 1'b0; op_ack = 1'b0;

        // 1: reset
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_reset();
        check_outputs("reset");

        // 2: clean entry 1.0 / 2.0
        enter8(64'h3F800000_40000000);
        check_val("t2.n0", n0, 32'h3F800000);
        check_val("t2.n1", n1, 32'h40000000);
        check_val("t2.leds", {28'd0, leds}, 32'h8);
        check_outputs("t2");

        // 5: load presses in READY ignored, then ack
        press(8'hAA, 1'b1, 1'b0);
        press(8'h55, 1'b1, 1'b0);
        check_outputs("t5.ready");
        ack_pulse();
        check_val("t5.valid_after_ack", {31'd0, op_valid}, 32'd0);
        check_outputs("t5.ack");

        // 3: bounce produces nothing, a steady hold stores one byte
        sw = 8'h12;
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            tick(2);
        end
        btn_load = 1'b0;
        tick(4);
        check_outputs("t3.bounce");
        btn_load = 1'b1;
        tick(10);
        btn_load = 1'b0;
        tick(8);
        m_load(8'h12);
        check_val("t3.leds", {28'd0, leds}, 32'h1);
        check_outputs("t3.hold");

        // 4: clear after three bytes, then simultaneous load+clear
        press(8'h34, 1'b1, 1'b0);
        press(8'h56, 1'b1, 1'b0);
        check_outputs("t4.three");
        press(8'h00, 1'b0, 1'b1);
        check_outputs("t4.clear");
        press(8'h99, 1'b1, 1'b1);
        check_outputs("t4.both");

        // 6: special operands, then reset mid LOAD_B
        enter8(64'h7F800000_00000001);
        check_val("t6.special", {31'd0, op_special}, 32'd1);
        check_outputs("t6.entry");
        ack_pulse();
        for (int i = 0; i < 6; i++) press(8'(8'h11 * (i + 1)), 1'b1, 1'b0);
        check_outputs("t6.partial");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_reset();
        check_outputs("t6.reset");
        enter8(64'hC1200000_3E800000);
        check_outputs("t6.fresh");

        // Randomized mix of loads, clears, acks, bounces and collisions
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 8'($urandom);
            case (r)
                6: press(b, 1'b0, 1'b1);
                7: ack_pulse();
                8: begin
                    sw = b;
                    btn_load = 1'b1;
                    tick($urandom_range(1, 3));
                    btn_load = 1'b0;
                    tick(6);
                end
                9: press(b, 1'b1, 1'b1);
                default: press(b, 1'b1, 1'b0);
            endcase
            check_outputs($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
